// File: rtl/uram_read_stage_pkg.sv
// rtl/uram_read_stage_pkg.sv - shared constants for the URAM read stage
package uram_read_stage_pkg;

  // Response buffer depth; also the number of read credits the stage hands out.
  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/uram_read_stage_resp_fifo.sv
// rtl/uram_read_stage_resp_fifo.sv - small in-order response buffer
module resp_fifo
  import uram_read_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [FIFO_CNT_W-1:0] count_o
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_CNT_W-1:0] count_q, count_d;

  // Next pointer/occupancy; push and pop together leave the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) begin
      wr_ptr_d = (wr_ptr_q == FIFO_PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_i) begin
      rd_ptr_d = (rd_ptr_q == FIFO_PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    count_d = count_q + FIFO_CNT_W'(push_i) - FIFO_CNT_W'(pop_i);
  end

  // Pointer and occupancy state; reset drops anything buffered.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are meaningless until counted in by count_q.
  always_ff @(posedge clock) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_data_o = mem_q[rd_ptr_q];
  assign full_o      = (count_q == FIFO_CNT_W'(FIFO_DEPTH));
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;

endmodule

// File: rtl/uram_read_stage.sv
// rtl/uram_read_stage.sv - credit-flow read stage in front of a 1-cycle read-first URAM
module uram_read_stage
  import uram_read_stage_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic                     wr_valid,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    resp_data,
  output logic [ADDRESS_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0]    mem_dout,
  output logic                     mem_wen,
  output logic [ADDRESS_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0]    mem_din
);

  logic                  in_flight_q, in_flight_d;
  logic                  fwd_q, fwd_d;
  logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;

  logic                  accept;
  logic                  pop;
  logic                  addr_hit;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [FIFO_CNT_W:0]   committed;
  logic                  credit_avail;

  // The URAM ports are straight pass-throughs; writes are suppressed in reset.
  assign mem_raddr = req_addr;
  assign mem_wen   = wr_valid & reset;
  assign mem_waddr = wr_addr;
  assign mem_din   = wr_data;

  // A credit is held by every buffered response and by the read in flight.
  assign committed    = {1'b0, fifo_count} + (FIFO_CNT_W + 1)'(in_flight_q);
  assign credit_avail = committed < (FIFO_CNT_W + 1)'(FIFO_DEPTH);

  assign req_ready = reset & (credit_avail | pop);
  assign accept    = req_valid & req_ready;

  // The URAM is read-first, so a same-cycle write to the read address would
  // otherwise return stale data; capture the write value for that read.
  assign addr_hit = wr_valid & (wr_addr == req_addr);
  assign rd_data  = fwd_q ? fwd_data_q : mem_dout;

  // The in-flight read bypasses an empty FIFO so latency stays at one cycle.
  assign resp_valid = reset & (~fifo_empty | in_flight_q);
  assign resp_data  = !resp_valid ? '0 : (!fifo_empty ? fifo_head : rd_data);
  assign pop        = resp_valid & resp_ready;
  assign fifo_pop   = pop & ~fifo_empty;
  assign fifo_push  = in_flight_q & ~(fifo_empty & pop);

  // Next state of the one-cycle read pipeline.
  always_comb begin
    in_flight_d = accept;
    fwd_d       = accept & addr_hit;
    fwd_data_d  = (accept & addr_hit) ? wr_data : fwd_data_q;
  end

  // Read pipeline register; reset discards the read in flight.
  always_ff @(posedge clock) begin
    if (!reset) begin
      in_flight_q <= 1'b0;
      fwd_q       <= 1'b0;
      fwd_data_q  <= '0;
    end else begin
      in_flight_q <= in_flight_d;
      fwd_q       <= fwd_d;
      fwd_data_q  <= fwd_data_d;
    end
  end

  // Credit accounting must never let a response arrive at a full buffer.
  always_ff @(posedge clock) begin
    if (reset && fifo_push) begin
      assert (!fifo_full);
    end
  end

  resp_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_i     (fifo_push),
    .push_data_i(rd_data),
    .pop_i      (fifo_pop),
    .head_data_o(fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

endmodule
